// File: rtl/channel_initial_selection.sv
// Channel-side initial-selection sequencer for one bus-and-tag channel:
// address out, select, command out, status in, service out, then report a result.
module channel_initial_selection #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned SETUP_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       start_valid,
    output logic       start_ready,
    input  logic [7:0] start_address,
    input  logic [7:0] start_command,
    output logic       result_valid,
    input  logic       result_ready,
    output logic [1:0] result_code,
    output logic [7:0] result_status,
    output logic [7:0] bus_out,
    input  logic [7:0] bus_in,
    output logic       operational_out,
    output logic       hold_out,
    output logic       select_out,
    output logic       address_out,
    output logic       command_out,
    output logic       service_out,
    output logic       suppress_out,
    input  logic       operational_in,
    input  logic       select_in,
    input  logic       address_in,
    input  logic       status_in
);

    localparam int unsigned TMR_W  = 16;
    localparam int unsigned SYNC_W = 12;

    localparam logic [1:0] RC_OK       = 2'd0;
    localparam logic [1:0] RC_NODEV    = 2'd1;
    localparam logic [1:0] RC_TIMEOUT  = 2'd2;
    localparam logic [1:0] RC_MISMATCH = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE, ST_ASETUP, ST_ASEL, ST_SEL, ST_CSETUP,
        ST_CMD, ST_STAT, ST_SVC, ST_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [TMR_W-1:0]   timer, timer_nxt;
    logic [7:0]         addr_q, addr_nxt, cmd_q, cmd_nxt;
    logic               start_ready_nxt, result_valid_nxt;
    logic [1:0]         result_code_nxt;
    logic [7:0]         result_status_nxt, bus_out_nxt;
    logic               hold_nxt, select_nxt, address_nxt, command_nxt, service_nxt;
    logic               do_abort;
    logic [1:0]         abort_code;
    logic               setup_done, timeout_hit;

    logic [SYNC_W-1:0]  sync_q [SYNC_STAGES];
    logic [7:0]         bus_in_s;
    logic               op_s, sel_s, addr_s, stat_s;

    // Inbound tags and bus share one synchroniser chain so they stay aligned
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {bus_in, operational_in, select_in, address_in, status_in};
            for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign {bus_in_s, op_s, sel_s, addr_s, stat_s} = sync_q[SYNC_STAGES-1];

    assign suppress_out = 1'b0;

    // Timeout fires on the cycle the timer would reach TIMEOUT_CYCLES
    assign setup_done  = (timer == TMR_W'(SETUP_CYCLES - 1));
    assign timeout_hit = (timer == TMR_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nxt         = state;
        addr_nxt          = addr_q;
        cmd_nxt           = cmd_q;
        start_ready_nxt   = start_ready;
        result_valid_nxt  = result_valid;
        result_code_nxt   = result_code;
        result_status_nxt = result_status;
        bus_out_nxt       = bus_out;
        hold_nxt          = hold_out;
        select_nxt        = select_out;
        address_nxt       = address_out;
        command_nxt       = command_out;
        service_nxt       = service_out;
        do_abort          = 1'b0;
        abort_code        = RC_OK;
        timer_nxt         = '0;

        case (state)
            ST_IDLE: begin
                start_ready_nxt = 1'b1;
                if (start_valid && start_ready) begin
                    addr_nxt        = start_address;
                    cmd_nxt         = start_command;
                    bus_out_nxt     = start_address;
                    start_ready_nxt = 1'b0;
                    state_nxt       = ST_ASETUP;
                end
            end
            ST_ASETUP: begin
                if (setup_done) begin
                    address_nxt = 1'b1;
                    state_nxt   = ST_ASEL;
                end
            end
            ST_ASEL: begin
                if (setup_done) begin
                    select_nxt  = 1'b1;
                    hold_nxt    = 1'b1;
                    address_nxt = 1'b0;
                    state_nxt   = ST_SEL;
                end
            end
            ST_SEL: begin
                if (sel_s) begin
                    do_abort   = 1'b1;
                    abort_code = RC_NODEV;
                end else if (op_s && addr_s) begin
                    if (bus_in_s != addr_q) begin
                        do_abort   = 1'b1;
                        abort_code = RC_MISMATCH;
                    end else begin
                        bus_out_nxt = cmd_q;
                        state_nxt   = ST_CSETUP;
                    end
                end else if (timeout_hit) begin
                    do_abort   = 1'b1;
                    abort_code = RC_TIMEOUT;
                end
            end
            ST_CSETUP: begin
                if (setup_done) begin
                    command_nxt = 1'b1;
                    state_nxt   = ST_CMD;
                end
            end
            ST_CMD: begin
                if (!op_s || (addr_s && timeout_hit)) begin
                    do_abort   = 1'b1;
                    abort_code = RC_TIMEOUT;
                end else if (!addr_s) begin
                    command_nxt = 1'b0;
                    bus_out_nxt = 8'h00;
                    state_nxt   = ST_STAT;
                end
            end
            ST_STAT: begin
                if (!op_s || (!stat_s && timeout_hit)) begin
                    do_abort   = 1'b1;
                    abort_code = RC_TIMEOUT;
                end else if (stat_s) begin
                    result_status_nxt = bus_in_s;
                    service_nxt       = 1'b1;
                    state_nxt         = ST_SVC;
                end
            end
            ST_SVC: begin
                if (!op_s || (stat_s && timeout_hit)) begin
                    do_abort   = 1'b1;
                    abort_code = RC_TIMEOUT;
                end else if (!stat_s) begin
                    service_nxt      = 1'b0;
                    select_nxt       = 1'b0;
                    hold_nxt         = 1'b0;
                    result_code_nxt  = RC_OK;
                    result_valid_nxt = 1'b1;
                    state_nxt        = ST_DONE;
                end
            end
            ST_DONE: begin
                if (result_valid && result_ready) begin
                    result_valid_nxt = 1'b0;
                    state_nxt        = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Abort: drop the handshake at once, no orderly disconnect
        if (do_abort) begin
            hold_nxt          = 1'b0;
            select_nxt        = 1'b0;
            address_nxt       = 1'b0;
            command_nxt       = 1'b0;
            service_nxt       = 1'b0;
            bus_out_nxt       = 8'h00;
            result_code_nxt   = abort_code;
            result_status_nxt = 8'h00;
            result_valid_nxt  = 1'b1;
            state_nxt         = ST_DONE;
        end

        if (state_nxt == state && state != ST_IDLE && state != ST_DONE)
            timer_nxt = timer + TMR_W'(1);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state           <= ST_IDLE;
            timer           <= '0;
            addr_q          <= 8'h00;
            cmd_q           <= 8'h00;
            start_ready     <= 1'b1;
            result_valid    <= 1'b0;
            result_code     <= RC_OK;
            result_status   <= 8'h00;
            bus_out         <= 8'h00;
            operational_out <= 1'b0;
            hold_out        <= 1'b0;
            select_out      <= 1'b0;
            address_out     <= 1'b0;
            command_out     <= 1'b0;
            service_out     <= 1'b0;
        end else begin
            state           <= state_nxt;
            timer           <= timer_nxt;
            addr_q          <= addr_nxt;
            cmd_q           <= cmd_nxt;
            start_ready     <= start_ready_nxt;
            result_valid    <= result_valid_nxt;
            result_code     <= result_code_nxt;
            result_status   <= result_status_nxt;
            bus_out         <= bus_out_nxt;
            operational_out <= 1'b1;
            hold_out        <= hold_nxt;
            select_out      <= select_nxt;
            address_out     <= address_nxt;
            command_out     <= command_nxt;
            service_out     <= service_nxt;
        end
    end

endmodule

// File: tb/tb_channel_initial_selection.sv
// Directed bench for channel_initial_selection with a small reactive control-unit model.
module tb_channel_initial_selection;

    localparam int unsigned SYNC_STAGES    = 2;
    localparam int unsigned SETUP_CYCLES   = 4;
    localparam int unsigned TIMEOUT_CYCLES = 50;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       start_valid = 1'b0;
    logic       start_ready;
    logic [7:0] start_address = 8'h00;
    logic [7:0] start_command = 8'h00;
    logic       result_valid;
    logic       result_ready = 1'b0;
    logic [1:0] result_code;
    logic [7:0] result_status;
    logic [7:0] bus_out;
    logic [7:0] bus_in = 8'h00;
    logic       operational_out, hold_out, select_out, address_out;
    logic       command_out, service_out, suppress_out;
    logic       operational_in = 1'b0;
    logic       select_in = 1'b0;
    logic       address_in = 1'b0;
    logic       status_in = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // CU model configuration
    logic       cu_nodev = 1'b0;
    logic       cu_stuck = 1'b0;
    logic [7:0] cu_resp = 8'hE0;
    logic [7:0] cu_status = 8'h00;
    int         cu_phase = 0;

    // Tag rise monitor
    logic prev_addr = 1'b0, prev_sel = 1'b0, prev_hold = 1'b0, prev_cmd = 1'b0, prev_svc = 1'b0;
    int   addr_rise = 0, sel_rise = 0, hold_rise = 0, cmd_rise = 0, svc_rise = 0, cmd_cnt = 0;
    logic [7:0] bus_at_addr = 8'h00, bus_at_cmd = 8'h00;

    channel_initial_selection #(
        .SYNC_STAGES(SYNC_STAGES),
        .SETUP_CYCLES(SETUP_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .start_valid(start_valid), .start_ready(start_ready),
        .start_address(start_address), .start_command(start_command),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_code(result_code), .result_status(result_status),
        .bus_out(bus_out), .bus_in(bus_in),
        .operational_out(operational_out), .hold_out(hold_out),
        .select_out(select_out), .address_out(address_out),
        .command_out(command_out), .service_out(service_out),
        .suppress_out(suppress_out),
        .operational_in(operational_in), .select_in(select_in),
        .address_in(address_in), .status_in(status_in)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    always @(negedge aclk) begin
        prev_addr <= address_out;
        prev_sel  <= select_out;
        prev_hold <= hold_out;
        prev_cmd  <= command_out;
        prev_svc  <= service_out;
        if (address_out && !prev_addr) begin addr_rise <= cyc; bus_at_addr <= bus_out; end
        if (select_out && !prev_sel) sel_rise <= cyc;
        if (hold_out && !prev_hold) hold_rise <= cyc;
        if (command_out && !prev_cmd) begin cmd_rise <= cyc; bus_at_cmd <= bus_out; cmd_cnt <= cmd_cnt + 1; end
        if (service_out && !prev_svc) svc_rise <= cyc;
    end

    // Reactive control unit driving the inbound tags and bus_in
    always @(negedge aclk) begin
        if (cu_nodev) begin
            select_in = select_out;
            operational_in = 1'b0; address_in = 1'b0; status_in = 1'b0; bus_in = 8'h00;
            cu_phase = 0;
        end else begin
            select_in = 1'b0;
            if (!select_out) begin
                operational_in = 1'b0; address_in = 1'b0; status_in = 1'b0; bus_in = 8'h00;
                cu_phase = 0;
            end else begin
                case (cu_phase)
                    0: begin operational_in = 1'b1; address_in = 1'b1; bus_in = cu_resp; cu_phase = 1; end
                    1: if (command_out && !cu_stuck) begin address_in = 1'b0; bus_in = 8'h00; cu_phase = 2; end
                    2: if (!command_out) begin status_in = 1'b1; bus_in = cu_status; cu_phase = 3; end
                    3: if (service_out) begin status_in = 1'b0; bus_in = 8'h00; cu_phase = 4; end
                    default: ;
                endcase
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue_start(input logic [7:0] a, input logic [7:0] c);
        int n = 0;
        @(negedge aclk);
        start_address = a;
        start_command = c;
        start_valid   = 1'b1;
        while (!start_ready && n < 20) begin @(negedge aclk); n++; end
        check("start_ready_wait", 32'(start_ready), 32'd1);
        @(negedge aclk);
        start_valid = 1'b0;
        check("start_ready_drop", 32'(start_ready), 32'd0);
    endtask

    task automatic wait_result(output logic [1:0] code, output logic [7:0] st, output int rv_cyc);
        int n = 0;
        while (!result_valid && n < 500) begin @(negedge aclk); n++; end
        check("result_wait", 32'(result_valid), 32'd1);
        code   = result_code;
        st     = result_status;
        rv_cyc = cyc;
    endtask

    task automatic consume();
        repeat (2) begin
            @(negedge aclk);
            check("valid_hold", 32'(result_valid), 32'd1);
        end
        result_ready = 1'b1;
        @(negedge aclk);
        result_ready = 1'b0;
        check("valid_drop", 32'(result_valid), 32'd0);
        check("start_ready_lag", 32'(start_ready), 32'd0);
        @(negedge aclk);
        check("start_ready_back", 32'(start_ready), 32'd1);
    endtask

    task automatic check_idle_tags(input string tag);
        check({tag, "_hold"}, 32'(hold_out), 32'd0);
        check({tag, "_sel"},  32'(select_out), 32'd0);
        check({tag, "_addr"}, 32'(address_out), 32'd0);
        check({tag, "_cmd"},  32'(command_out), 32'd0);
        check({tag, "_svc"},  32'(service_out), 32'd0);
        check({tag, "_bus"},  32'(bus_out), 32'h00);
    endtask

    initial begin
        logic [1:0] code;
        logic [7:0] st;
        int rv_cyc;
        int cnt0;
        int n;

        // Reset state
        repeat (3) @(negedge aclk);
        check_idle_tags("rst");
        check("rst_op", 32'(operational_out), 32'd0);
        check("rst_start_ready", 32'(start_ready), 32'd1);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_code", 32'(result_code), 32'd0);
        check("rst_status", 32'(result_status), 32'h00);
        aresetn = 1'b1;
        @(negedge aclk);
        check("op_after_rst", 32'(operational_out), 32'd1);
        check("suppress", 32'(suppress_out), 32'd0);

        // Normal selection, status 0x00
        cu_resp = 8'hE0; cu_status = 8'h00;
        issue_start(8'hE0, 8'h02);
        wait_result(code, st, rv_cyc);
        check("ok_code", 32'(code), 32'd0);
        check("ok_status", 32'(st), 32'h00);
        check("ok_order_a_s", 32'(addr_rise < sel_rise), 32'd1);
        check("ok_order_s_c", 32'(sel_rise < cmd_rise), 32'd1);
        check("ok_order_c_v", 32'(cmd_rise < svc_rise), 32'd1);
        check("ok_hold_with_sel", 32'(hold_rise), 32'(sel_rise));
        check("ok_asel_wait", 32'(sel_rise - addr_rise), 32'(SETUP_CYCLES));
        check("ok_bus_at_addr", 32'(bus_at_addr), 32'hE0);
        check("ok_bus_at_cmd", 32'(bus_at_cmd), 32'h02);
        check_idle_tags("ok_end");
        consume();

        // Busy CU: one command_out pulse, busy status returned
        cu_status = 8'h10;
        cnt0 = cmd_cnt;
        issue_start(8'hE0, 8'h02);
        wait_result(code, st, rv_cyc);
        check("busy_code", 32'(code), 32'd0);
        check("busy_status", 32'(st), 32'h10);
        check("busy_cmd_once", 32'(cmd_cnt - cnt0), 32'd1);
        consume();

        // Different address/command/status pattern
        cu_resp = 8'h33; cu_status = 8'hA5;
        issue_start(8'h33, 8'h04);
        wait_result(code, st, rv_cyc);
        check("alt_code", 32'(code), 32'd0);
        check("alt_status", 32'(st), 32'hA5);
        check("alt_bus_at_cmd", 32'(bus_at_cmd), 32'h04);
        consume();

        // Address mismatch: no command pulse, status cleared
        cu_resp = 8'hE1; cu_status = 8'h77;
        cnt0 = cmd_cnt;
        issue_start(8'hE0, 8'h02);
        wait_result(code, st, rv_cyc);
        check("mis_code", 32'(code), 32'd3);
        check("mis_status", 32'(st), 32'h00);
        check("mis_no_cmd", 32'(cmd_cnt - cnt0), 32'd0);
        check_idle_tags("mis_end");
        consume();

        // No device: select loops back
        cu_nodev = 1'b1;
        issue_start(8'h40, 8'h02);
        wait_result(code, st, rv_cyc);
        check("nodev_code", 32'(code), 32'd1);
        check("nodev_latency", 32'(rv_cyc - sel_rise <= int'(SYNC_STAGES) + 2), 32'd1);
        check("nodev_op", 32'(operational_out), 32'd1);
        check_idle_tags("nodev_end");
        consume();
        cu_nodev = 1'b0;

        // Timeout: CU never drops address_in
        cu_resp = 8'hE0; cu_status = 8'h00; cu_stuck = 1'b1;
        issue_start(8'hE0, 8'h02);
        wait_result(code, st, rv_cyc);
        check("tmo_code", 32'(code), 32'd2);
        check("tmo_latency", 32'(rv_cyc - cmd_rise), 32'(TIMEOUT_CYCLES));
        check_idle_tags("tmo_end");
        consume();
        cu_stuck = 1'b0;

        // One-cycle reset while service_out is high, then a fresh request
        cu_status = 8'h10;
        issue_start(8'hE0, 8'h02);
        n = 0;
        while (!service_out && n < 500) begin @(negedge aclk); n++; end
        check("svc_seen", 32'(service_out), 32'd1);
        aresetn = 1'b0;
        @(negedge aclk);
        check_idle_tags("mrst");
        check("mrst_op", 32'(operational_out), 32'd0);
        check("mrst_start_ready", 32'(start_ready), 32'd1);
        check("mrst_valid", 32'(result_valid), 32'd0);
        check("mrst_status", 32'(result_status), 32'h00);
        aresetn = 1'b1;
        @(negedge aclk);
        check("mrst_op_back", 32'(operational_out), 32'd1);
        issue_start(8'hE0, 8'h02);
        wait_result(code, st, rv_cyc);
        check("post_rst_code", 32'(code), 32'd0);
        check("post_rst_status", 32'(st), 32'h10);
        consume();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/channel_initial_selection.md
Name: channel_initial_selection

Overview:
- Channel-side sequencer for one parallel (bus-and-tag) channel. It runs a complete initial-selection sequence against an attached control unit: address out, select, command out, then status in and service out.
- A single start request supplies the device address and command byte. The block returns the CU's initial status byte or an error code.
- It sits between the channel AXI register block (upstream) and the channel "B" tag/bus lines driven into mock_cu or real hardware.

Parameters:
- SYNC_STAGES, 2, number of flip-flop synchroniser stages on each inbound tag and on bus_in (minimum 2).
- SETUP_CYCLES, 4, aclk cycles that bus_out must be stable before address_out or command_out rises.
- TIMEOUT_CYCLES, 1000, maximum aclk cycles spent in any single wait state before aborting (1..65535).

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- start_valid  in  1  selection request
- start_ready  out  1  block idle and able to accept a request
- start_address  in  8  device address
- start_command  in  8  command byte
- result_valid  out  1  result available
- result_ready  in  1  result consumed
- result_code  out  2  0=OK, 1=NO_DEVICE, 2=TIMEOUT, 3=ADDR_MISMATCH
- result_status  out  8  CU status byte (valid only when result_code=0)
- bus_out  out  8  channel bus out
- bus_in  in  8  channel bus in (asynchronous)
- operational_out, hold_out, select_out, address_out, command_out, service_out, suppress_out  out  1 each  outbound tags
- operational_in, select_in, address_in, status_in  in  1 each  inbound tags (asynchronous)

Behaviour:
- Reset values: all outbound tags 0, bus_out=0, start_ready=1, result_valid=0, result_code=0, result_status=0, state=IDLE, timer=0.
- operational_out is 1 whenever aresetn=1. suppress_out is always 0.
- Inbound tags and bus_in pass through the SYNC_STAGES synchroniser; all rules below refer to the synchronised values.
- Reset asserted mid-sequence: every output returns to its reset value on the next edge. There is no orderly disconnect.
- Timer: cleared on every state entry and incremented once per cycle in the wait states SEL, CMD, STAT and SVC. When timer==TIMEOUT_CYCLES, the block aborts with code 2.
- Abort (any error): drop every outbound tag except operational_out, set bus_out=0, go to DONE.
- IDLE:
  - start_ready=1.
  - On start_valid&&start_ready: latch address and command, set bus_out=address, start_ready←0, go to ASETUP.
- ASETUP: wait SETUP_CYCLES cycles, then set address_out=1 and go to ASEL.
- ASEL: wait SETUP_CYCLES cycles, then set select_out=1, hold_out=1, address_out=0 and go to SEL.
- SEL (first matching condition wins, evaluated each cycle):
  - select_in=1: no device responded; abort with code 1.
  - operational_in&&address_in: compare bus_in with the latched address.
    - Mismatch: abort with code 3.
    - Match: set bus_out=command and go to CSETUP.
  - Timeout: abort with code 2.
- CSETUP: wait SETUP_CYCLES cycles, then set command_out=1 and go to CMD.
- CMD:
  - On address_in=0: set command_out=0, bus_out=0, go to STAT.
  - On timeout: abort with code 2.
- STAT:
  - On status_in=1: latch bus_in into result_status, set service_out=1, go to SVC.
  - On timeout: abort with code 2.
- SVC:
  - On status_in=0: set service_out=0, select_out=0, hold_out=0, result_code=0, go to DONE.
  - On timeout: abort with code 2.
- DONE:
  - result_valid=1; it is held stable until result_ready.
  - On the cycle after result_valid&&result_ready: result_valid=0 and the block returns to IDLE.
  - start_ready rises one cycle after the result is consumed (back-to-back starts are therefore at least 2 cycles apart).
- If operational_in drops while in CMD, STAT or SVC, abort with code 2 immediately; this is treated as a CU disconnect.
- result_status is forced to 0 on any error code.

Test Plan:
- Address 0xE0, command 0x02; mock CU answers address 0xE0 and status 0x00 → outbound tag order address_out, select_out+hold_out, command_out, service_out; result_code=0, result_status=0x00.
- Mock CU busy (mock_busy=1) at address 0xE0 → result_code=0, result_status=0x10 (busy bit), command_out never accepted twice.
- Address 0x40 with no device present (select_out looped back to select_in) → result_code=1 within SYNC_STAGES+2 cycles of select_out rising; all tags except operational_out are 0.
- CU answers on bus_in with 0xE1 for a requested 0xE0 → result_code=3, no command_out pulse.
- TIMEOUT_CYCLES=50, CU holds address_in high forever → result_code=2 exactly 50 cycles after CMD entry; command_out and select_out drop.
- aresetn=0 for one cycle while service_out=1 → all outputs at reset values on the next edge; start_ready=1; a fresh request then completes with code 0.
